// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants and types for the PS/2 set-2 scan-code decoder.
//   - scan-code constants for the prefix bytes and modifier keys
//   - character codes emitted for the extended arrow keys
//   - prefix FSM state encoding
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] CH_UP     = 8'h80;
  localparam logic [7:0] CH_DOWN   = 8'h81;
  localparam logic [7:0] CH_LEFT   = 8'h82;
  localparam logic [7:0] CH_RIGHT  = 8'h83;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

endpackage

// File: rtl/kbd_ascii_rom.sv
// kbd_ascii_rom: combinational set-2 make-code to character lookup.
// Ports:
//   i_scan_code  make code (prefixes already stripped)
//   i_ext        1 when the code followed an E0 prefix
//   i_shift      either Shift key held
//   i_caps       Caps Lock state
//   o_char       translated character (0x00 when no hit)
//   o_hit        1 when the code produces a character
module kbd_ascii_rom
  import kbd_pkg::*;
(
  input  logic [7:0] i_scan_code,
  input  logic       i_ext,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_char,
  output logic       o_hit
);

  logic [7:0] w_lower;  // lowercase letter, 0 if not a letter
  logic [7:0] w_dig;    // unshifted digit, 0 if not a digit key
  logic [7:0] w_sym;    // shifted symbol on the digit row
  logic [7:0] w_misc;   // space / control keys, 0 otherwise

  always_comb begin
    w_lower = '0;
    w_dig   = '0;
    w_sym   = '0;
    w_misc  = '0;
    case (i_scan_code)
      8'h1C: w_lower = 8'h61;  8'h32: w_lower = 8'h62;  8'h21: w_lower = 8'h63;
      8'h23: w_lower = 8'h64;  8'h24: w_lower = 8'h65;  8'h2B: w_lower = 8'h66;
      8'h34: w_lower = 8'h67;  8'h33: w_lower = 8'h68;  8'h43: w_lower = 8'h69;
      8'h3B: w_lower = 8'h6A;  8'h42: w_lower = 8'h6B;  8'h4B: w_lower = 8'h6C;
      8'h3A: w_lower = 8'h6D;  8'h31: w_lower = 8'h6E;  8'h44: w_lower = 8'h6F;
      8'h4D: w_lower = 8'h70;  8'h15: w_lower = 8'h71;  8'h2D: w_lower = 8'h72;
      8'h1B: w_lower = 8'h73;  8'h2C: w_lower = 8'h74;  8'h3C: w_lower = 8'h75;
      8'h2A: w_lower = 8'h76;  8'h1D: w_lower = 8'h77;  8'h22: w_lower = 8'h78;
      8'h35: w_lower = 8'h79;  8'h1A: w_lower = 8'h7A;
      8'h45: begin w_dig = 8'h30; w_sym = 8'h29; end
      8'h16: begin w_dig = 8'h31; w_sym = 8'h21; end
      8'h1E: begin w_dig = 8'h32; w_sym = 8'h40; end
      8'h26: begin w_dig = 8'h33; w_sym = 8'h23; end
      8'h25: begin w_dig = 8'h34; w_sym = 8'h24; end
      8'h2E: begin w_dig = 8'h35; w_sym = 8'h25; end
      8'h36: begin w_dig = 8'h36; w_sym = 8'h5E; end
      8'h3D: begin w_dig = 8'h37; w_sym = 8'h26; end
      8'h3E: begin w_dig = 8'h38; w_sym = 8'h2A; end
      8'h46: begin w_dig = 8'h39; w_sym = 8'h28; end
      8'h29: w_misc = 8'h20;
      8'h5A: w_misc = 8'h0D;
      8'h66: w_misc = 8'h08;
      8'h76: w_misc = 8'h1B;
      8'h0D: w_misc = 8'h09;
      default: ;
    endcase

    o_char = '0;
    o_hit  = 1'b0;
    if (i_ext) begin
      case (i_scan_code)
        8'h75: begin o_char = CH_UP;    o_hit = 1'b1; end
        8'h72: begin o_char = CH_DOWN;  o_hit = 1'b1; end
        8'h6B: begin o_char = CH_LEFT;  o_hit = 1'b1; end
        8'h74: begin o_char = CH_RIGHT; o_hit = 1'b1; end
        default: ;
      endcase
    end else if (w_lower != '0) begin
      o_char = (i_shift ^ i_caps) ? (w_lower - 8'h20) : w_lower;
      o_hit  = 1'b1;
    end else if (w_dig != '0) begin
      o_char = i_shift ? w_sym : w_dig;
      o_hit  = 1'b1;
    end else if (w_misc != '0) begin
      o_char = w_misc;
      o_hit  = 1'b1;
    end
  end

endmodule

// File: rtl/kbd_decode.sv
// kbd_decode: PS/2 set-2 scan-code decoder with Shift/Caps tracking and a
// first-word-fall-through character FIFO.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   scan_code     scan code from receiver, valid with scan_valid
//   scan_valid    one-cycle strobe per scan code
//   char_out      FIFO head character, 0x00 when empty
//   char_valid    FIFO not empty
//   char_rd       pop strobe, ignored when empty
//   caps_led      Caps Lock state
//   overflow      sticky, a character was dropped on a full FIFO
module kbd_decode
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_rd,
  output logic       caps_led,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_make, w_ext, w_brk;
  logic   w_is_prefix;

  logic   r_shift_l, r_shift_r, r_caps, r_overflow;
  logic   w_shift;
  logic [7:0] w_char;
  logic   w_hit;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_we, w_push, w_pop, w_full, w_empty;

  assign w_is_prefix = (scan_code == SC_BREAK) || (scan_code == SC_EXT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)    w_state_nxt = ST_BRK;
          else if (scan_code == SC_EXT) w_state_nxt = ST_EXT;
        end
        ST_BRK:  w_state_nxt = ST_IDLE;
        ST_EXT: begin
          if (scan_code == SC_BREAK)    w_state_nxt = ST_EXT_BRK;
          else if (scan_code == SC_EXT) w_state_nxt = ST_EXT;
          else                          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_make = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (scan_valid) begin
      case (r_state)
        ST_IDLE: w_make = !w_is_prefix;
        ST_BRK:  w_brk  = 1'b1;
        ST_EXT: begin
          w_make = !w_is_prefix;
          w_ext  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Modifiers only respond to non-extended codes; an extended break is
  // swallowed without touching them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
      r_caps    <= 1'b0;
    end else begin
      if (w_make && !w_ext) begin
        if (scan_code == SC_LSHIFT) r_shift_l <= 1'b1;
        if (scan_code == SC_RSHIFT) r_shift_r <= 1'b1;
        if (scan_code == SC_CAPS)   r_caps    <= ~r_caps;
      end
      if (w_brk) begin
        if (scan_code == SC_LSHIFT) r_shift_l <= 1'b0;
        if (scan_code == SC_RSHIFT) r_shift_r <= 1'b0;
      end
    end
  end

  assign w_shift = r_shift_l | r_shift_r;

  kbd_ascii_rom u_rom (
    .i_scan_code (scan_code),
    .i_ext       (w_ext),
    .i_shift     (w_shift),
    .i_caps      (r_caps),
    .o_char      (w_char),
    .o_hit       (w_hit)
  );

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_we    = w_make && w_hit;
  assign w_pop   = char_rd && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = w_we && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: ;
      endcase
      if (w_we && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign char_valid = !w_empty;
  assign char_out   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign caps_led   = r_caps;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_kbd_decode.sv
module tb_kbd_decode;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_rd;
  logic       caps_led;
  logic       overflow;

  kbd_decode #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_rd    (char_rd),
    .caps_led   (caps_led),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference tables: letter codes a..z, digit codes 0..9, shifted symbols.
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                 8'h3D, 8'h3E, 8'h46};
  logic [7:0] digit_sym [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
                                 8'h26, 8'h2A, 8'h28};
  logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h15, 8'h1A, 8'h16,
                            8'h45, 8'h1E, 8'h29, 8'h5A, 8'h66, 8'h12, 8'h59, 8'h58,
                            8'hF0, 8'hE0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h70, 8'h0E};

  // Behavioural model state
  logic [7:0] mq [$];
  bit m_ovf, m_caps, m_shl, m_shr, m_f0, m_e0;

  function automatic int xlate(logic [7:0] c, bit ext, bit sh, bit cp);
    if (ext) begin
      case (c)
        8'h75: return 'h80;
        8'h72: return 'h81;
        8'h6B: return 'h82;
        8'h74: return 'h83;
        default: return -1;
      endcase
    end
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) return ((sh ^ cp) ? 'h41 : 'h61) + i;
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == c) return sh ? int'(digit_sym[i]) : 'h30 + i;
    case (c)
      8'h29: return 'h20;
      8'h5A: return 'h0D;
      8'h66: return 'h08;
      8'h76: return 'h1B;
      8'h0D: return 'h09;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_caps = 0; m_shl = 0; m_shr = 0; m_f0 = 0; m_e0 = 0;
  endtask

  task automatic model_cycle(input bit valid, input logic [7:0] c, input bit rd);
    int x;
    bit ext;
    if (rd && mq.size() > 0) void'(mq.pop_front());
    if (!valid) return;
    if (m_f0) begin
      if (!m_e0) begin
        if (c == 8'h12) m_shl = 0;
        if (c == 8'h59) m_shr = 0;
      end
      m_f0 = 0;
      m_e0 = 0;
      return;
    end
    if (c == 8'hF0) begin m_f0 = 1; return; end
    if (c == 8'hE0) begin m_e0 = 1; return; end
    ext  = m_e0;
    m_e0 = 0;
    x = xlate(c, ext, m_shl | m_shr, m_caps);
    if (!ext) begin
      if (c == 8'h12) m_shl = 1;
      if (c == 8'h59) m_shr = 1;
      if (c == 8'h58) m_caps = !m_caps;
    end
    if (x >= 0) begin
      if (mq.size() < DEPTH) mq.push_back(8'(x));
      else m_ovf = 1;
    end
  endtask

  task automatic drive(input bit valid, input logic [7:0] c, input bit rd);
    scan_valid = valid;
    scan_code  = c;
    char_rd    = rd;
    model_cycle(valid, c, rd);
    @(negedge clk);
    scan_valid = 1'b0;
    char_rd    = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    drive(1'b1, c, 1'b0);
  endtask

  task automatic pop();
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    send(8'h58);
    send(8'h1C);
    do_reset();
    n_checks++; if (char_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", char_valid); else n_pass++;
    n_checks++; if (char_out !== 8'h00) $display("FAIL reset_char: got %h want 00", char_out); else n_pass++;
    n_checks++; if (caps_led !== 1'b0) $display("FAIL reset_caps: got %b want 0", caps_led); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_single_key();
    send(8'h1C);
    n_checks++; if (char_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", char_valid); else n_pass++;
    n_checks++; if (char_out !== 8'h61) $display("FAIL single_char: got %h want 61", char_out); else n_pass++;
    send(8'hF0);
    send(8'h1C);
    pop();
    n_checks++; if (char_valid !== 1'b0) $display("FAIL single_count: got valid %b want 0", char_valid); else n_pass++;
  endtask

  task automatic test_shift();
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    n_checks++; if (char_out !== 8'h41) $display("FAIL shift_upper: got %h want 41", char_out); else n_pass++;
    pop();
    n_checks++; if (char_out !== 8'h61) $display("FAIL shift_lower: got %h want 61", char_out); else n_pass++;
    pop();
    n_checks++; if (char_valid !== 1'b0) $display("FAIL shift_extra: got valid %b want 0", char_valid); else n_pass++;
  endtask

  task automatic test_caps();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    n_checks++; if (caps_led !== 1'b1) $display("FAIL caps_led: got %b want 1", caps_led); else n_pass++;
    n_checks++; if (char_out !== 8'h41) $display("FAIL caps_upper: got %h want 41", char_out); else n_pass++;
    pop();
    send(8'h12); send(8'h1C);
    n_checks++; if (char_out !== 8'h61) $display("FAIL caps_shift_letter: got %h want 61", char_out); else n_pass++;
    pop();
    send(8'h16);
    n_checks++; if (char_out !== 8'h21) $display("FAIL caps_shift_digit: got %h want 21", char_out); else n_pass++;
    pop();
    send(8'hF0); send(8'h12);
    n_checks++; if (char_valid !== 1'b0) $display("FAIL caps_extra: got valid %b want 0", char_valid); else n_pass++;
  endtask

  task automatic test_extended();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'hE0); send(8'h70);
    n_checks++; if (char_out !== 8'h80) $display("FAIL ext_up: got %h want 80", char_out); else n_pass++;
    pop();
    n_checks++; if (char_valid !== 1'b0) $display("FAIL ext_extra: got valid %b want 0", char_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_a [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    logic [7:0] exp_b [4] = '{8'h62, 8'h63, 8'h64, 8'h66};
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (char_out !== exp_a[i]) $display("FAIL ovf_drain%0d: got %h want %h", i, char_out, exp_a[i]); else n_pass++;
      pop();
    end
    n_checks++; if (char_valid !== 1'b0) $display("FAIL ovf_empty: got valid %b want 0", char_valid); else n_pass++;
    // full, then simultaneous pop and write
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    drive(1'b1, 8'h2B, 1'b1);
    n_checks++; if (overflow !== 1'b0) $display("FAIL rw_full_ovf: got %b want 0", overflow); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (char_out !== exp_b[i]) $display("FAIL rw_full_drain%0d: got %h want %h", i, char_out, exp_b[i]); else n_pass++;
      pop();
    end
    n_checks++; if (char_valid !== 1'b0) $display("FAIL rw_full_empty: got valid %b want 0", char_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    send(8'hF0);
    do_reset();
    send(8'h1C);
    n_checks++; if (char_out !== 8'h61) $display("FAIL rst_mid_char: got %h want 61", char_out); else n_pass++;
    pop();
    pop();
    n_checks++; if (char_valid !== 1'b0) $display("FAIL empty_rd_valid: got %b want 0", char_valid); else n_pass++;
    n_checks++; if (char_out !== 8'h00) $display("FAIL empty_rd_char: got %h want 00", char_out); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL empty_rd_ovf: got %b want 0", overflow); else n_pass++;
    send(8'h32);
    n_checks++; if (char_out !== 8'h62) $display("FAIL empty_rd_next: got %h want 62", char_out); else n_pass++;
    pop();
  endtask

  task automatic test_random();
    logic [7:0] exp_c;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 70, pool[$urandom_range(0, 23)], $urandom_range(0, 99) < 45);
      exp_c = (mq.size() > 0) ? mq[0] : 8'h00;
      n_checks++; if (char_valid !== (mq.size() > 0)) $display("FAIL rand_valid@%0d: got %b want %b", n, char_valid, mq.size() > 0); else n_pass++;
      n_checks++; if (char_out !== exp_c) $display("FAIL rand_char@%0d: got %h want %h", n, char_out, exp_c); else n_pass++;
      n_checks++; if (caps_led !== m_caps) $display("FAIL rand_caps@%0d: got %b want %b", n, caps_led, m_caps); else n_pass++;
      n_checks++; if (overflow !== m_ovf) $display("FAIL rand_ovf@%0d: got %b want %b", n, overflow, m_ovf); else n_pass++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    char_rd    = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_key();
    test_shift();
    test_caps();
    test_extended();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
